// File: rtl/pulse_dly_array.sv
// pulse_dly_array: per-channel programmable delay line with flush-on-retune config port
//   clk, rst          : single clock, synchronous active-high reset
//   din, din_vld      : channel c payload at din[c*W +: W], valid at din_vld[c]
//   dout, dout_vld    : delayed payload (zero when not valid) and delayed valid
//   cfg_wr/ch/dly     : one-cycle delay write strobe, target channel, requested delay
//   cfg_ack, cfg_err  : registered accept / reject pulse for the previous write
//   dly_q             : current delay of channel c at dly_q[c*DW +: DW]
module pulse_dly_array #(
    parameter int NCH = 4,
    parameter int W = 1,
    parameter int MAX_DLY = 7,
    parameter int RST_DLY = 0,
    localparam int DW = $clog2(MAX_DLY + 1),
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  din,
    input  logic [NCH-1:0]    din_vld,
    output logic [NCH*W-1:0]  dout,
    output logic [NCH-1:0]    dout_vld,
    input  logic              cfg_wr,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [DW-1:0]     cfg_dly,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NCH*DW-1:0] dly_q
);
    logic [MAX_DLY-1:0][W:0] ln_q [NCH];
    logic [MAX_DLY-1:0][W:0] ln_d [NCH];
    logic [MAX_DLY:0][W:0]   tap  [NCH];
    logic [(1<<CW)-1:0]      ch_ok;
    logic [(1<<DW)-1:0]      dly_ok;
    logic                    wr_ok;
    // Range checks go through constant lookup tables so they stay correct
    // whether or not NCH / MAX_DLY fill their select widths.
    always_comb begin
        for (int i = 0; i < (1 << CW); i++) ch_ok[i] = (i < NCH);
        for (int i = 0; i < (1 << DW); i++) dly_ok[i] = (i <= MAX_DLY);
        wr_ok = cfg_wr && ch_ok[cfg_ch] && dly_ok[cfg_dly];
        dout = '0;
        dout_vld = '0;
        for (int c = 0; c < NCH; c++) begin
            // tap[k] is the sample delayed by k cycles; tap[0] is the live input
            tap[c] = {ln_q[c], {din_vld[c], din[c*W +: W]}};
            ln_d[c] = (wr_ok && cfg_ch == CW'(c)) ? '0 : tap[c][MAX_DLY-1:0];
            dout_vld[c] = tap[c][dly_q[c*DW +: DW]][W];
            dout[c*W +: W] = dout_vld[c] ? tap[c][dly_q[c*DW +: DW]][W-1:0] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                ln_q[c] <= '0;
                dly_q[c*DW +: DW] <= DW'(RST_DLY);
            end
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                ln_q[c] <= ln_d[c];
                if (wr_ok && cfg_ch == CW'(c)) dly_q[c*DW +: DW] <= cfg_dly;
            end
            cfg_ack <= wr_ok;
            cfg_err <= cfg_wr && !wr_ok;
        end
    end
endmodule

// File: tb/tb_pulse_dly_array.sv
// tb_pulse_dly_array: history-based model of pulse_dly_array plus directed literal checks
module tb_pulse_dly_array;
    localparam int NCH = 3, W = 8, MAX_DLY = 6, RST_DLY = 0, DW = 3, CW = 2;
    logic clk = 1'b0, rst;
    logic [NCH*W-1:0] din, dout;
    logic [NCH-1:0] din_vld, dout_vld;
    logic cfg_wr, cfg_ack, cfg_err;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_dly;
    logic [NCH*DW-1:0] dly_q;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pulse_dly_array #(.NCH(NCH), .W(W), .MAX_DLY(MAX_DLY), .RST_DLY(RST_DLY)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(dout), .dout_vld(dout_vld),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_dly(cfg_dly), .cfg_ack(cfg_ack),
        .cfg_err(cfg_err), .dly_q(dly_q)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: every input sample is logged by cycle; an output at cycle t with
    // delay d is the sample of cycle t-d unless that sample predates the last
    // flush of the channel (reset or accepted write).
    int cyc = 0;
    bit started = 1'b0;
    int mdly [NCH];
    int fs [NCH];
    logic eack = 1'b0, eerr = 1'b0;
    bit ok;
    logic [W:0] hist [0:4095][NCH];

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                mdly[c] = RST_DLY;
                fs[c] = cyc + 1;
            end
            eack = 1'b0;
            eerr = 1'b0;
            started = 1'b1;
        end else begin
            ok = cfg_wr && (int'(cfg_ch) < NCH) && (int'(cfg_dly) <= MAX_DLY);
            eack = ok;
            eerr = cfg_wr && !ok;
            if (ok) begin
                mdly[cfg_ch] = int'(cfg_dly);
                fs[cfg_ch] = cyc + 1;
            end
        end
        cyc++;
    end

    logic [NCH*W-1:0] ed;
    logic [NCH-1:0] ev;
    logic [NCH*DW-1:0] edq;
    int s;
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) hist[cyc][c] = {din_vld[c], din[c*W +: W]};
        if (started) begin
            for (int c = 0; c < NCH; c++) begin
                s = cyc - mdly[c];
                ev[c] = (s >= fs[c]) ? hist[s][c][W] : 1'b0;
                ed[c*W +: W] = ev[c] ? hist[s][c][W-1:0] : '0;
                edq[c*DW +: DW] = DW'(mdly[c]);
            end
            chk("m_vld", dout_vld, ev);
            chk("m_dout", dout, ed);
            chk("m_dly", dly_q, edq);
            chk("m_ack", cfg_ack, eack);
            chk("m_err", cfg_err, eerr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; din = '0; din_vld = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_dly = '0;
        step(); step();
        rst = 1'b0;
        // passthrough at reset delay 0
        din[2*W +: W] = 8'hA5; din_vld = 3'b100;
        @(negedge clk);
        chk("lit_pass_dout", dout, 24'hA50000);
        chk("lit_pass_vld", dout_vld, 3'b100);
        chk("lit_rst_dly", dly_q, 9'd0);
        step();
        din = '0; din_vld = '0;
        // fixed delay 3 on ch1
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_dly = 3'd3;
        step();
        cfg_wr = 1'b0;
        @(negedge clk);
        chk("lit_fix_ack", cfg_ack, 1);
        chk("lit_fix_dly", dly_q[5:3], 3);
        repeat (4) step();
        din[15:8] = 8'h3C; din_vld = 3'b010;
        step();
        din = '0; din_vld = '0;
        step();
        @(negedge clk);
        chk("lit_fix_t7_vld", dout_vld, 0);
        step();
        @(negedge clk);
        chk("lit_fix_t8_dout", dout, 24'h003C00);
        chk("lit_fix_t8_vld", dout_vld, 3'b010);
        step();
        // max depth on ch0
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_dly = 3'd6;
        step();
        cfg_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din[7:0] = 8'(i + 1); din_vld[0] = 1'b1;
            @(negedge clk);
            if (i == 5) chk("lit_max_pre", dout_vld[0], 0);
            if (i == 6) begin
                chk("lit_max_rise", dout_vld[0], 1);
                chk("lit_max_data", dout[7:0], 8'h01);
            end
            if (i == 9) chk("lit_max_hold", dout_vld[0], 1);
            step();
        end
        // retune mid-stream: 6 -> 5 at k=0, 5 -> 2 at k=10
        for (int k = 0; k < 20; k++) begin
            din[7:0] = 8'(8'h40 + k); din_vld[0] = 1'b1;
            cfg_wr = (k == 0) || (k == 10); cfg_ch = 2'd0; cfg_dly = (k == 0) ? 3'd5 : 3'd2;
            @(negedge clk);
            if (k == 6) chk("lit_rt5_first", dout[7:0], 8'h41);
            if (k == 10) chk("lit_rt_old_dly", dout[7:0], 8'h45);
            if (k == 11 || k == 12) chk("lit_rt_gap", dout_vld[0], 0);
            if (k == 13) begin
                chk("lit_rt2_vld", dout_vld[0], 1);
                chk("lit_rt2_data", dout[7:0], 8'h4B);
            end
            step();
        end
        cfg_wr = 1'b0;
        // illegal delay then illegal channel
        din[7:0] = 8'h77; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_dly = 3'd7;
        step();
        cfg_wr = 1'b0; din[7:0] = 8'h78;
        @(negedge clk);
        chk("lit_bad_dly_err", cfg_err, 1);
        chk("lit_bad_dly_ack", cfg_ack, 0);
        chk("lit_bad_dly_keep", dly_q[2:0], 2);
        chk("lit_bad_dly_noflush", dout_vld[0], 1);
        step();
        cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_dly = 3'd1;
        step();
        cfg_wr = 1'b0;
        @(negedge clk);
        chk("lit_bad_ch_err", cfg_err, 1);
        chk("lit_bad_ch_dly", dly_q, 9'b000_011_010);
        step();
        // retune to 0: follows din from T+1
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_dly = 3'd0; din[7:0] = 8'h90;
        step();
        cfg_wr = 1'b0; din[7:0] = 8'h91;
        @(negedge clk);
        chk("lit_d0_data", dout[7:0], 8'h91);
        step();
        // back-to-back writes on ch2
        din[23:16] = 8'h10; din_vld[2] = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_dly = 3'd4;
        step();
        din[23:16] = 8'h11; cfg_dly = 3'd1;
        @(negedge clk);
        chk("lit_b2b_ack1", cfg_ack, 1);
        step();
        cfg_wr = 1'b0; din[23:16] = 8'h12;
        @(negedge clk);
        chk("lit_b2b_ack2", cfg_ack, 1);
        chk("lit_b2b_dly", dly_q[8:6], 1);
        chk("lit_b2b_flush", dout_vld[2], 0);
        step();
        din[23:16] = 8'h13;
        @(negedge clk);
        chk("lit_b2b_out", dout[23:16], 8'h12);
        step();
        // reset during traffic, with a simultaneous write
        din = 24'h332211; din_vld = 3'b111;
        rst = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_dly = 3'd5;
        step();
        rst = 1'b0; cfg_wr = 1'b0;
        @(negedge clk);
        chk("lit_rst_dlyq", dly_q, 9'd0);
        chk("lit_rst_ack", cfg_ack, 0);
        chk("lit_rst_pass", dout, 24'h332211);
        repeat (3) step();
        din_vld = '0;
        repeat (3) step();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
